dmem_responder: RTL and testbench

Data-memory responder for the RV32I core's load/store port, sitting on the memory side of the core's data address, write-data and read-data path. It accepts one load or store request at a time over a valid/ready handshake. It performs byte/halfword/word access with byte-lane merging on stores and sign/zero extension on loads. It returns a single response after a programmable wait latency and flags misaligned or illegal requests.

---
 rtl/dmem_responder.sv | 185 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store port: one request at a time,
// programmable wait states, byte-lane store merge and extended loads.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [2:0]          r_funct3;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;

    logic [31:0]         r_mem [DEPTH];

    logic                w_req_err;
    logic [ADDR_W-3:0]   w_idx;
    logic [3:0]          w_be;
    logic [31:0]         w_wword;
    logic [31:0]         w_load;

    // Illegal size codes or a halfword/word access that straddles its natural boundary.
    function automatic logic f_req_err(input logic we, input logic [2:0] f3,
                                       input logic [1:0] a);
        logic illegal;
        logic misaligned;
        if (we)
            illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        else
            illegal = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                     ((f3[1:0] == 2'b10) && (a != 2'b00));
        return illegal || misaligned;
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic        [31:0] res;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h  = a[1] ? w[31:16] : w[15:0];
        sb = signed'(b);
        sh = signed'(h);
        case (f3)
            3'b000:  res = 32'(sb);
            3'b001:  res = 32'(sh);
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = w;
        endcase
        return res;
    endfunction

    assign w_req_err = f_req_err(req_we, req_funct3, req_addr[1:0]);
    assign w_idx     = r_addr[ADDR_W-1:2];
    assign w_load    = f_load(r_mem[w_idx], r_funct3, r_addr[1:0]);

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be    = 4'b1111;
        w_wword = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wword = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wword = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wword = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_funct3     <= 3'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_funct3    <= req_funct3;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'd0;
                        end else if (LATENCY == 0) begin
                            r_state <= S_ACCESS;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 4'(LATENCY);
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1)
                        r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    r_resp_rdata <= r_we ? 32'd0 : w_load;
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The array is never reset; async rst leaves ACCESS before any edge can commit.
    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS && r_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at LATENCY=1, one at LATENCY=3.
module tb_dmem_responder;

    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]          rst;
    logic [1:0]          req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0][31:0]    req_wdata, resp_rdata;
    logic [1:0][2:0]     req_funct3;

    int lat_cfg [2] = '{1, 3};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl [8];

    dmem_responder #(.ADDR_W(AW), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.ADDR_W(AW), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction on instance d; hold = cycles resp_ready stays low after resp_valid.
    task automatic txn(input int d, input logic we, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [2:0] f3,
                       input logic [31:0] erd, input logic eerr, input int hold);
        exp_t e;
        int   lat;
        int   n;
        @(negedge clk);
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        req_funct3[d] = f3;
        @(posedge clk);
        e.rdata = erd;
        e.err   = eerr;
        e.lat   = eerr ? 0 : lat_cfg[d] + 1;
        sb_q.push_back(e);
        #1 req_valid[d] = 1'b0;
        lat = 0;
        while (!resp_valid[d] && lat < 40) begin
            check("req_ready_busy", 32'(req_ready[d]), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb_q.pop_front();
        check("resp_valid", 32'(resp_valid[d]), 32'd1);
        check("latency", 32'(lat), 32'(e.lat));
        check("rdata", resp_rdata[d], e.rdata);
        check("err", 32'(resp_err[d]), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(resp_valid[d]), 32'd1);
            check("bp_rdata", resp_rdata[d], e.rdata);
            check("bp_err", 32'(resp_err[d]), 32'(e.err));
            check("bp_req_ready", 32'(req_ready[d]), 32'd0);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1 resp_ready[d] = 1'b0;
        check("done_valid", 32'(resp_valid[d]), 32'd0);
        check("done_req_ready", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 2'b11;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        resp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", 32'(req_ready[d]), 32'd1);
            check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
            check("rst_rdata", resp_rdata[d], 32'd0);
            check("rst_err", 32'(resp_err[d]), 32'd0);
        end
        @(negedge clk);
        rst = 2'b00;

        // word store/load, then sub-word merges
        txn(0, 1'b1, 8'h10, 32'hFAFF7B80, 3'b010, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 8'h10, 32'h0,        3'b010, 32'hFAFF7B80, 1'b0, 0);
        txn(0, 1'b1, 8'h11, 32'h000000A5, 3'b000, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 8'h10, 32'h0,        3'b010, 32'hFAFFA580, 1'b0, 0);
        txn(0, 1'b1, 8'h12, 32'h00001234, 3'b001, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 8'h10, 32'h0,        3'b010, 32'h1234A580, 1'b0, 0);

        // load extension
        txn(0, 1'b0, 8'h11, 32'h0, 3'b000, 32'hFFFFFFA5, 1'b0, 0);
        txn(0, 1'b0, 8'h11, 32'h0, 3'b100, 32'h000000A5, 1'b0, 0);
        txn(0, 1'b0, 8'h10, 32'h0, 3'b001, 32'hFFFFA580, 1'b0, 0);
        txn(0, 1'b0, 8'h10, 32'h0, 3'b101, 32'h0000A580, 1'b0, 0);
        txn(0, 1'b0, 8'h12, 32'h0, 3'b001, 32'h00001234, 1'b0, 0);

        // errors: misaligned and illegal size codes, memory untouched
        txn(0, 1'b0, 8'h12, 32'h0,        3'b010, 32'h0, 1'b1, 0);
        txn(0, 1'b1, 8'h13, 32'h0000FFFF, 3'b001, 32'h0, 1'b1, 0);
        txn(0, 1'b0, 8'h10, 32'h0,        3'b011, 32'h0, 1'b1, 0);
        txn(0, 1'b1, 8'h10, 32'h000000EE, 3'b100, 32'h0, 1'b1, 0);
        txn(0, 1'b1, 8'h10, 32'h11111111, 3'b110, 32'h0, 1'b1, 0);
        txn(0, 1'b0, 8'h10, 32'h0,        3'b010, 32'h1234A580, 1'b0, 0);

        // random word traffic against a reference array
        for (int i = 0; i < 8; i++) begin
            mdl[i] = $urandom;
            txn(0, 1'b1, 8'(8'h40 + 4 * i), mdl[i], 3'b010, 32'h0, 1'b0, 0);
        end
        for (int i = 7; i >= 0; i--)
            txn(0, 1'b0, 8'(8'h40 + 4 * i), 32'h0, 3'b010, mdl[i], 1'b0, 0);

        // LATENCY=3 with backpressure
        txn(1, 1'b1, 8'h30, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 0);
        txn(1, 1'b0, 8'h30, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0, 5);
        txn(1, 1'b0, 8'h31, 32'h0,        3'b011, 32'h0, 1'b1, 2);

        // reset during WAIT discards the store
        txn(1, 1'b1, 8'h20, 32'h00000000, 3'b010, 32'h0, 1'b0, 0);
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b1;
        req_addr[1]   = 8'h20;
        req_wdata[1]  = 32'hDEADBEEF;
        req_funct3[1] = 3'b010;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        check("mid_busy", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(req_ready[1]), 32'd1);
        check("mid_rst_resp_valid", 32'(resp_valid[1]), 32'd0);
        check("mid_rst_rdata", resp_rdata[1], 32'd0);
        check("mid_rst_err", 32'(resp_err[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("mid_no_resp", 32'(resp_valid[1]), 32'd0);
        end
        txn(1, 1'b0, 8'h20, 32'h0, 3'b010, 32'h00000000, 1'b0, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
